// File: rtl/trap_controller_pkg.sv
// Shared definitions for the trap controller: FSM state encoding, event kind,
// interrupt cause codes and the default flush hold length.
package trap_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_COMMIT   = 2'd2,
    ST_REDIRECT = 2'd3
  } state_t;

  typedef enum logic {
    KIND_TRAP = 1'b0,
    KIND_MRET = 1'b1
  } kind_t;

  localparam logic [3:0] CAUSE_EIP = 4'd11;
  localparam logic [3:0] CAUSE_SIP = 4'd3;
  localparam logic [3:0] CAUSE_TIP = 4'd7;

  localparam int unsigned FLUSH_CYCLES_DEFAULT = 3;

endpackage

// File: rtl/trap_controller_priority.sv
// trap_priority: combinational event selection for the trap controller.
// Ports:
//   exception_valid/exception_cause : writeback fault and its cause
//   mret_valid                      : writeback holds mret
//   retire_valid                    : an instruction retired this cycle
//   eip/sip/tip                     : pending+enabled interrupt lines
//   accept                          : some event is taken this cycle
//   kind                            : trap or mret
//   cause/interupt                  : cause code and interrupt flag for traps
module trap_priority
  import trap_controller_pkg::*;
(
  input  logic       exception_valid,
  input  logic [3:0] exception_cause,
  input  logic       mret_valid,
  input  logic       retire_valid,
  input  logic       eip,
  input  logic       sip,
  input  logic       tip,
  output logic       accept,
  output kind_t      kind,
  output logic [3:0] cause,
  output logic       interupt
);

  // Interrupts are taken only on a clean retirement so the resume PC is known.
  logic int_ok;
  assign int_ok = retire_valid & ~exception_valid;

  always_comb begin
    accept   = 1'b0;
    kind     = KIND_TRAP;
    cause    = 4'd0;
    interupt = 1'b0;
    if (exception_valid) begin
      accept = 1'b1;
      cause  = exception_cause;
    end else if (mret_valid) begin
      accept = 1'b1;
      kind   = KIND_MRET;
    end else if (int_ok && eip) begin
      accept   = 1'b1;
      cause    = CAUSE_EIP;
      interupt = 1'b1;
    end else if (int_ok && sip) begin
      accept   = 1'b1;
      cause    = CAUSE_SIP;
      interupt = 1'b1;
    end else if (int_ok && tip) begin
      accept   = 1'b1;
      cause    = CAUSE_TIP;
      interupt = 1'b1;
    end
  end

endmodule

// File: rtl/trap_controller.sv
// trap_controller: sequences trap entry and mret by flushing the pipeline,
// pulsing the csr, then redirecting fetch.
// Ports:
//   clk, reset_n (sync, active-low)
//   exception_*/mret_valid/retire_*/eip/tip/sip : writeback events
//   flush_done      : pipeline empty report
//   flush           : squash/stall, high throughout DRAIN
//   traped/mret     : one-cycle csr pulses in COMMIT
//   ecp/trap_cause/interupt : latched trap info, held until next acceptance
//   redirect_valid/redirect_sel : one-cycle fetch redirect (1 = mret_vector)
//
// state    | meaning
// IDLE     | waiting for an event; only state that samples events
// DRAIN    | flush held; leaves once hold counter is 0 and flush_done=1
// COMMIT   | one-cycle traped or mret pulse
// REDIRECT | one-cycle fetch redirect
module trap_controller
  import trap_controller_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        exception_valid,
  input  logic [3:0]  exception_cause,
  input  logic [31:0] exception_pc,
  input  logic        mret_valid,
  input  logic        retire_valid,
  input  logic [31:0] retire_next_pc,
  input  logic        eip,
  input  logic        tip,
  input  logic        sip,
  input  logic        flush_done,
  output logic        flush,
  output logic        traped,
  output logic        mret,
  output logic [31:0] ecp,
  output logic [3:0]  trap_cause,
  output logic        interupt,
  output logic        redirect_valid,
  output logic        redirect_sel
);

  localparam logic [3:0] HOLD_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  kind_t      kind;

  logic       acc;
  kind_t      acc_kind;
  logic [3:0] acc_cause;
  logic       acc_int;

  trap_priority u_priority (
    .exception_valid (exception_valid),
    .exception_cause (exception_cause),
    .mret_valid      (mret_valid),
    .retire_valid    (retire_valid),
    .eip             (eip),
    .sip             (sip),
    .tip             (tip),
    .accept          (acc),
    .kind            (acc_kind),
    .cause           (acc_cause),
    .interupt        (acc_int)
  );

  logic take;
  assign take = (state == ST_IDLE) && acc;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      kind       <= KIND_TRAP;
      ecp        <= 32'd0;
      trap_cause <= 4'd0;
      interupt   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (take) begin
        kind <= acc_kind;
        // mret keeps the previously latched trap info
        if (acc_kind == KIND_TRAP) begin
          ecp        <= acc_int ? retire_next_pc : exception_pc;
          trap_cause <= acc_cause;
          interupt   <= acc_int;
        end
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    flush          = 1'b0;
    traped         = 1'b0;
    mret           = 1'b0;
    redirect_valid = 1'b0;
    redirect_sel   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (acc) begin
          state_nxt = ST_DRAIN;
          cnt_nxt   = HOLD_LOAD;
        end
      end
      ST_DRAIN: begin
        flush = 1'b1;
        if (cnt == 4'd0) begin
          if (flush_done) state_nxt = ST_COMMIT;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_COMMIT: begin
        traped    = (kind == KIND_TRAP);
        mret      = (kind == KIND_MRET);
        state_nxt = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_sel   = (kind == KIND_MRET);
        state_nxt      = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: doc/trap_controller.md
TRAP_CONTROLLER -- requirements
Module: trap_controller

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 3: minimum cycles flush is held (legal 1..15).
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  single clock.
- reset_n  in  1  synchronous, active-low reset.
- exception_valid  in  1  writeback instruction faulted.
- exception_cause  in  4  cause code of that fault.
- exception_pc  in  32  PC of faulting instruction.
- mret_valid  in  1  writeback holds mret.
- retire_valid  in  1  writeback retired an instruction this cycle.
- retire_next_pc  in  32  PC following the retired instruction.
- eip  in  1  external interrupt pending and enabled (from csr).
- tip  in  1  timer interrupt pending and enabled (from csr).
- sip  in  1  software interrupt pending and enabled (from csr).
- flush_done  in  1  pipeline reports all stages empty.
- flush  out  1  squash all stages and stall fetch.
- traped  out  1  one-cycle trap-entry pulse to csr.
- mret  out  1  one-cycle mret pulse to csr.
- ecp  out  32  trap PC to csr.
- trap_cause  out  4  cause to csr.
- interupt  out  1  cause is an interrupt.
- redirect_valid  out  1  one-cycle fetch redirect pulse.
- redirect_sel  out  1  0 = trap_vector, 1 = mret_vector.

Function
REQ-003 SHALL implement FSM IDLE -> DRAIN -> COMMIT -> REDIRECT -> IDLE.
REQ-004 In IDLE, event priority SHALL be: exception_valid > mret_valid > eip > sip > tip.
REQ-005 Interrupts SHALL be accepted only in a cycle with retire_valid=1 and exception_valid=0; interrupt ecp = retire_next_pc.
REQ-006 On acceptance, SHALL latch ecp, trap_cause, interupt and kind (trap/mret) and enter DRAIN next cycle.
- Exception: ecp=exception_pc, cause=exception_cause, interupt=0.
- eip: cause 11; sip: cause 3; tip: cause 7; all interupt=1.
- mret: ecp and cause unchanged.
REQ-007 flush SHALL be 1 in every DRAIN cycle and 0 otherwise.
REQ-008 A 4-bit counter SHALL load FLUSH_CYCLES-1 on DRAIN entry and decrement to 0, saturating.
REQ-009 DRAIN SHALL exit to COMMIT on the first cycle with counter==0 and flush_done=1; flush_done earlier is ignored.
REQ-010 COMMIT SHALL last one cycle: traped=1 for trap kind, or mret=1 for mret kind; never both.
REQ-011 REDIRECT SHALL last one cycle: redirect_valid=1, redirect_sel = (kind==mret).
REQ-012 Minimum event-to-redirect latency SHALL be FLUSH_CYCLES+2 cycles after the acceptance edge.
REQ-013 All inputs except flush_done SHALL be ignored outside IDLE; interrupts are level-sensitive and re-evaluated on return to IDLE.
REQ-014 ecp, trap_cause and interupt SHALL hold their latched values from acceptance until the next acceptance.
REQ-015 exception_valid and mret_valid together SHALL take the exception; mret is dropped.

Reset
REQ-016 reset_n=0 at a clk edge SHALL force state IDLE, counter 0, and all outputs to 0 (including ecp and trap_cause).
REQ-017 Reset asserted in any state SHALL abort the sequence: no traped, mret or redirect_valid pulse follows.
REQ-018 First acceptance SHALL be possible on the first edge after reset_n returns to 1.

Structure
REQ-019 A shared package SHALL hold the state encoding (2 bits), the interrupt cause constants 11/3/7, and the FLUSH_CYCLES default.
REQ-020 Priority selection SHALL live in one combinational sub-module trap_priority (inputs valid/interrupt lines; outputs accept, kind, cause, interupt).

Verification
REQ-021 Bench SHALL cover these directed scenarios:
- Exception, cause 2, pc 0x100, flush_done=1 throughout, FLUSH_CYCLES=3 -> flush 3 cycles; traped with ecp 0x100, cause 2, interupt 0; then redirect_valid with sel 0.
- mret_valid, flush_done delayed 6 cycles -> flush for 6 cycles; mret pulse; redirect sel 1; traped stays 0.
- eip=tip=sip=1, retire_valid=1, retire_next_pc 0x200 -> cause 11, interupt 1, ecp 0x200; with eip=0 -> cause 3.
- tip=1, retire_valid=0 -> no acceptance; acceptance on first cycle retire_valid=1.
- exception_valid and mret_valid in the same cycle -> traped only; tip raised during DRAIN -> ignored until IDLE.
- reset_n=0 during DRAIN -> flush 0 next cycle; no traped or redirect pulse follows.
